// File: rtl/digit_serial_addsub.sv
// digit_serial_addsub: DIGIT-bits-per-clock adder/subtractor over WIDTH-bit operands
// with start/busy/done handshake and signed-overflow flag.  Rev 1.0
`default_nettype none

module digit_serial_addsub #(
   parameter int WIDTH = 256,
   parameter int DIGIT = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int N  = WIDTH / DIGIT;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic             carry;
   logic [CW-1:0]    cnt;
   logic [DIGIT:0]   dsum;
   logic             msb_cin;
   logic [WIDTH-1:0] acc_next;

   assign dsum = {1'b0, op_a[DIGIT-1:0]} + {1'b0, op_b[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry};

   // Carry into the digit's top bit, recovered from the sum bit and its operands.
   assign msb_cin = op_a[DIGIT-1] ^ op_b[DIGIT-1] ^ dsum[DIGIT-1];

   generate
      if (DIGIT == WIDTH) begin : g_single
         assign acc_next = dsum[DIGIT-1:0];
      end else begin : g_multi
         // Holds the N-1 most recent digits; the newest digit enters at the top.
         logic [WIDTH-DIGIT-1:0] acc;

         assign acc_next = {dsum[DIGIT-1:0], acc};

         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               acc <= '0;
            end else if (state == RUN) begin
               acc <= acc_next[WIDTH-1:DIGIT];
            end
         end
      end
   endgenerate

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
         op_a  <= '0;
         op_b  <= '0;
         carry <= 1'b0;
         cnt   <= '0;
         sum   <= '0;
         cout  <= 1'b0;
         ovf   <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               done <= 1'b0;
               if (start) begin
                  op_a  <= a;
                  op_b  <= sub ? ~b : b;
                  carry <= sub ? ~cin : cin;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= RUN;
               end else begin
                  state <= IDLE;
               end
            end
            RUN: begin
               op_a  <= op_a >> DIGIT;
               op_b  <= op_b >> DIGIT;
               carry <= dsum[DIGIT];
               if (cnt == LAST) begin
                  cnt   <= '0;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  sum   <= acc_next;
                  cout  <= dsum[DIGIT];
                  ovf   <= msb_cin ^ dsum[DIGIT];
                  state <= DONE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

`default_nettype wire
